state_dump_sequencer: RTL and testbench

//  Sits downstream of the single-cycle machine in the datapath autograder harness. Watches the fetched

---
 rtl/state_dump_sequencer.sv | 151 +++++++++++++++
 tb/tb_state_dump_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/state_dump_sequencer.sv
// rtl/state_dump_sequencer.sv - end-of-program detector and register/memory dump streamer
// Optional feature macro: PC_TRACE_EN (streams each RUN-cycle pc as tag-0 words, adds trace_overflow)
module state_dump_sequencer #(
   parameter int          TIMEOUT_CYCLES = 64,
   parameter int          NUM_REGS       = 32,
   parameter logic [31:0] MEM_BASE       = 32'h4000,
   parameter int          MEM_WORDS      = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] inst,
   input  logic [31:0] pc,
   output logic [4:0]  rf_addr,
   input  logic [31:0] rf_data,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [1:0]  out_tag,
   output logic        halted,
   output logic        halt_timeout,
`ifdef PC_TRACE_EN
   output logic        trace_overflow,
`endif
   output logic        done
);

   localparam logic [2:0] S_RUN  = 3'd0;
   localparam logic [2:0] S_REGS = 3'd1;
   localparam logic [2:0] S_MEM  = 3'd2;
   localparam logic [2:0] S_END  = 3'd3;
   localparam logic [2:0] S_FIN  = 3'd4;

   localparam logic [31:0] LAST_RUN_COUNT = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] LAST_REG_INDEX = 32'(NUM_REGS - 1);
   localparam logic [31:0] LAST_MEM_INDEX = 32'(MEM_WORDS - 1);

   localparam logic [1:0] TAG_PC  = 2'd0;
   localparam logic [1:0] TAG_REG = 2'd1;
   localparam logic [1:0] TAG_MEM = 2'd2;
   localparam logic [1:0] TAG_END = 2'd3;

   logic [2:0]  state;
   logic [31:0] count;
   logic [31:0] index;
   logic        slot_free;
   logic        zero_inst;
   logic        budget_hit;
   logic        accepted;

   // The single output entry may take a new word when empty or being drained this edge
   assign slot_free  = !out_valid || out_ready;
   assign accepted   = out_valid && out_ready;
   assign zero_inst  = (inst == 32'h0);
   assign budget_hit = (count == LAST_RUN_COUNT);

   // Read-port addresses follow the walk index only in the phase that uses them
   assign rf_addr  = (state == S_REGS) ? index[4:0] : 5'd0;
   assign mem_addr = (state == S_MEM) ? (MEM_BASE + index) : MEM_BASE;

`ifndef PC_TRACE_EN
   logic unused_pc;
   assign unused_pc = ^pc;
`endif

   // Sequencer FSM and output register; a load later in the block overrides the post-accept drop
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_RUN;
         count        <= 32'd0;
         index        <= 32'd0;
         out_valid    <= 1'b0;
         out_data     <= 32'd0;
         out_tag      <= 2'd0;
         halted       <= 1'b0;
         halt_timeout <= 1'b0;
         done         <= 1'b0;
`ifdef PC_TRACE_EN
         trace_overflow <= 1'b0;
`endif
      end else begin
         if (accepted) begin
            out_valid <= 1'b0;
         end
         case (state)
            S_RUN: begin
               count <= count + 32'd1;
               if (zero_inst || budget_hit) begin
                  halted       <= 1'b1;
                  halt_timeout <= !zero_inst;
                  state        <= S_REGS;
                  index        <= 32'd0;
               end
`ifdef PC_TRACE_EN
               else if (slot_free) begin
                  out_valid <= 1'b1;
                  out_data  <= pc;
                  out_tag   <= TAG_PC;
               end else begin
                  trace_overflow <= 1'b1;
               end
`endif
            end
            S_REGS: begin
               if (slot_free) begin
                  out_valid <= 1'b1;
                  out_data  <= rf_data;
                  out_tag   <= TAG_REG;
                  if (index == LAST_REG_INDEX) begin
                     index <= 32'd0;
                     state <= S_MEM;
                  end else begin
                     index <= index + 32'd1;
                  end
               end
            end
            S_MEM: begin
               if (slot_free) begin
                  out_valid <= 1'b1;
                  out_data  <= mem_data;
                  out_tag   <= TAG_MEM;
                  if (index == LAST_MEM_INDEX) begin
                     index <= 32'd0;
                     state <= S_END;
                  end else begin
                     index <= index + 32'd1;
                  end
               end
            end
            S_END: begin
               if (slot_free) begin
                  out_valid <= 1'b1;
                  out_data  <= 32'd0;
                  out_tag   <= TAG_END;
                  state     <= S_FIN;
               end
            end
            S_FIN: begin
               if (accepted) begin
                  done <= 1'b1;
               end
            end
            default: begin
               state <= S_RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_state_dump_sequencer.sv
// tb/tb_state_dump_sequencer.sv - directed self-checking bench for state_dump_sequencer
module tb_state_dump_sequencer;

   localparam logic [31:0] NOP     = 32'h00000013;
   localparam logic [31:0] PC_BASE = 32'h00400000;
   localparam int          NREG    = 32;
   localparam int          NMEM    = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] inst = NOP;
   logic [31:0] pc = PC_BASE;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;
   logic [1:0]  out_tag;
   logic        halted;
   logic        halt_timeout;
   logic        done;
`ifdef PC_TRACE_EN
   logic        trace_overflow;
`endif

   int tests = 0;
   int fails = 0;
   int halt_seen;

   always #5 clk = ~clk;

   // register file holds r[i] = 3*i, memory window holds 0xA0.. at 0x4000..
   always_comb begin
      rf_data = 32'(rf_addr) * 32'd3;
      if ((mem_addr - 32'h4000) < 32'd4) mem_data = 32'hA0 + (mem_addr - 32'h4000);
      else mem_data = 32'hDEADBEEF;
   end

   state_dump_sequencer dut (
      .clk(clk), .reset(reset), .inst(inst), .pc(pc),
      .rf_addr(rf_addr), .rf_data(rf_data),
      .mem_addr(mem_addr), .mem_data(mem_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag),
      .halted(halted), .halt_timeout(halt_timeout),
`ifdef PC_TRACE_EN
      .trace_overflow(trace_overflow),
`endif
      .done(done)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] expected_word(input int j, input int npc);
      int k;
      k = j - npc;
      if (j < npc)            return {30'd0, 2'd0, PC_BASE + 32'(4 * j)};
      else if (k < NREG)      return {30'd0, 2'd1, 32'(3 * k)};
      else if (k < NREG+NMEM) return {30'd0, 2'd2, 32'hA0 + 32'(k - NREG)};
      else                    return {30'd0, 2'd3, 32'd0};
   endfunction

   // hold reset across one edge, then check the reset state
   task automatic hold_reset;
      reset = 1'b1; inst = NOP; pc = PC_BASE; out_ready = 1'b1;
      @(posedge clk); #1;
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_flags", {61'd0, halted, halt_timeout, done}, 64'd0);
      check("rst_addr", {27'd0, rf_addr, mem_addr}, {27'd0, 5'd0, 32'h4000});
      check("rst_word", {30'd0, out_tag, out_data}, 64'd0);
   endtask

   // release reset and run one program + dump, ready-policy mode 0=always 1=random after halt
   task automatic run_case(input int mode, input int halt_at, input bit zero, input int stop_after);
      int idx, npc, total, bubbles, quiet_viol;
      bit held;
      logic [63:0] held_word;
      idx = 0; bubbles = 0; quiet_viol = 0; held = 1'b0; held_word = '0; halt_seen = -1;
`ifdef PC_TRACE_EN
      npc = halt_at;
`else
      npc = 0;
`endif
      total = npc + NREG + NMEM + 1;
      reset = 1'b0;
      inst = (zero && halt_at == 0) ? 32'h0 : NOP;
      pc = PC_BASE;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (halted && halt_seen < 0) halt_seen = cyc;
         if (!halted && npc == 0 && out_valid) quiet_viol++;
         if (held) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_hold", {30'd0, out_tag, out_data}, held_word);
         end
         held = 1'b0;
         if (mode == 0 && idx > npc && idx < total && !out_valid) bubbles++;
         if (out_valid) begin
            if (out_ready) begin
               if (idx < total) check($sformatf("word%0d", idx), {30'd0, out_tag, out_data}, expected_word(idx, npc));
               idx++;
            end else begin
               held = 1'b1;
               held_word = {30'd0, out_tag, out_data};
            end
         end
         if (done) break;
         @(posedge clk);
         if (stop_after >= 0 && idx == stop_after) return;
         #1;
         inst = (zero && cyc + 1 == halt_at) ? 32'h0 : NOP;
         pc = PC_BASE + 32'(4 * (cyc + 1));
         out_ready = (mode == 1 && halted) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      check("word_count", 64'(idx), 64'(total));
      check("done", 64'(done), 64'd1);
      check("idle_valid", 64'(out_valid), 64'd0);
      check("halt_cycle", 64'(halt_seen), 64'(halt_at + 1));
      check("halt_timeout", 64'(halt_timeout), 64'(!zero));
      check("run_quiet", 64'(quiet_viol), 64'd0);
      if (mode == 0) check("no_bubbles", 64'(bubbles), 64'd0);
   endtask

   initial begin
      // 1: zero instruction at cycle 3, full throughput
      hold_reset();
      run_case(0, 3, 1'b1, -1);
      // 2: cycle budget expires on the 64th RUN cycle
      hold_reset();
      run_case(0, 63, 1'b0, -1);
      // 3: random backpressure during the dump
      hold_reset();
      run_case(1, 0, 1'b1, -1);
      // 4: reset in the middle of the dump, then a clean rerun
      hold_reset();
      run_case(0, 2, 1'b1, 10);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_halted", 64'(halted), 64'd0);
      run_case(0, 1, 1'b1, -1);
      // 5: zero instruction and budget on the same cycle
      hold_reset();
      run_case(0, 63, 1'b1, -1);
`ifdef PC_TRACE_EN
      // 6: trace word held under backpressure during RUN
      hold_reset();
      reset = 1'b0; out_ready = 1'b0; inst = NOP; pc = PC_BASE;
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk); #1;
         pc = PC_BASE + 32'(4 * i);
      end
      check("ovf_valid", 64'(out_valid), 64'd1);
      check("ovf_word", {30'd0, out_tag, out_data}, {30'd0, 2'd0, PC_BASE});
      check("ovf_flag", 64'(trace_overflow), 64'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      check("ovf_rst", 64'(trace_overflow), 64'd0);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
